// File: rtl/alu_input_ctrl.sv
// -----------------------------------------------------------------------------
// alu_input_ctrl
//   Input conditioning in front of the ALU. Raw buttons and switches are
//   brought into the clock domain with 2-flop synchronizers. The four opcode
//   buttons and the execute button are debounced. Each clean opcode press
//   toggles one bit of a held opcode register. A clean execute press
//   snapshots the switches and the opcode into registered outputs and then
//   fires a single-cycle enable to the ALU.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level change (>= 2)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk      in   board clock
//   reset_n  in   asynchronous active-low reset
//   btn_op   in   [3:0] raw opcode buttons {btnu, btnl, btnd, btnr}
//   btn_exec in   raw execute button (btnc)
//   sw       in   [15:0] raw switches (synchronized only)
//   a        out  [15:0] {sw[15:8], 8'h00} captured at snapshot
//   b        out  [15:0] {8'h00, sw[7:0]} captured at snapshot
//   op_code  out  [3:0] opcode captured at snapshot
//   enable   out  one-cycle strobe to the ALU
//   busy     out  high while an execute sequence is in progress
// -----------------------------------------------------------------------------
module alu_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  btn_op,
  input  logic        btn_exec,
  input  logic [15:0] sw,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [3:0]  op_code,
  output logic        enable,
  output logic        busy
);

  localparam int NB       = 5;  // opcode buttons in [3:0], execute in [4]
  localparam int EXEC_BIT = 4;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    FIRE     = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    btn_s1_q, btn_s2_q;
  logic [15:0]      sw_s1_q, sw_s2_q;
  logic [NB-1:0]    stable_q, stable_d;
  logic [NB-1:0]    stable_prev_q;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [3:0]       op_reg_q, op_reg_d;
  state_e           state_q, state_d;
  logic             load;
  logic [15:0]      a_q, b_q;
  logic [3:0]       op_code_q;

  assign btn_raw = {btn_exec, btn_op};

  // ---------------------------------------------------------------------------
  // Debounce: count consecutive cycles of disagreement between the synced and
  // the accepted level; accept the new level on the DEBOUNCE_CYCLES-th one.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rise of the accepted level against its one-cycle-delayed copy; releases
  // never produce a pulse.
  assign press    = stable_q & ~stable_prev_q;
  assign op_reg_d = op_reg_q ^ press[3:0];

  // ---------------------------------------------------------------------------
  // Execute sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE:     if (press[EXEC_BIT]) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = FIRE;
      end
      FIRE:     state_d = WAIT_REL;
      WAIT_REL: if (!stable_q[EXEC_BIT]) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q      <= '0;
      btn_s2_q      <= '0;
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared element by element like any other state.
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      op_reg_q      <= '0;
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_code_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the two synchronizer stages two distinct flops.
      btn_s1_q      <= btn_raw;
      btn_s2_q      <= btn_s1_q;
      sw_s1_q       <= sw;
      sw_s2_q       <= sw_s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      op_reg_q      <= op_reg_d;
      state_q       <= state_d;
      if (load) begin
        a_q       <= {sw_s2_q[15:8], 8'h00};
        b_q       <= {8'h00, sw_s2_q[7:0]};
        // Take the post-toggle value so a press landing in LOAD is included.
        op_code_q <= op_reg_d;
      end
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign op_code = op_code_q;
  assign enable  = (state_q == FIRE);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_input_ctrl
//   Directed bench for alu_input_ctrl with DEBOUNCE_CYCLES = 4. Inputs change
//   1 time unit after a rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_alu_input_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  btn_op;
  logic        btn_exec;
  logic [15:0] sw;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  op_code;
  logic        enable;
  logic        busy;

  int total  = 0;
  int passes = 0;

  alu_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_op  (btn_op),
    .btn_exec(btn_exec),
    .sw      (sw),
    .a       (a),
    .b       (b),
    .op_code (op_code),
    .enable  (enable),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold an opcode mask long enough to be accepted, then release and let the
  // release settle.
  task automatic press_op(input logic [3:0] mask);
    btn_op = mask;
    repeat (8) tick();
    btn_op = 4'b0000;
    repeat (10) tick();
  endtask

  // Hold btnc for 'hold' edges, then release and keep watching 15 more edges.
  // 'first' is the edge index (1 = first edge sampling the press) of the
  // first enable seen, -1 if none.
  task automatic run_exec(input int hold, output int first, output int count);
    first = -1;
    count = 0;
    btn_exec = 1'b1;
    for (int k = 1; k <= hold + 15; k++) begin
      if (k == hold + 1) btn_exec = 1'b0;
      tick();
      if (enable) begin
        count++;
        if (first < 0) first = k;
      end
    end
  endtask

  initial begin
    int first, count;
    logic busy6, busy7;

    // ---------------- Reset with buttons pressed ----------------
    reset_n  = 1'b0;
    btn_op   = 4'hF;
    btn_exec = 1'b1;
    sw       = 16'hFFFF;
    repeat (6) tick();
    check("rst_a",       a,       16'h0000);
    check("rst_b",       b,       16'h0000);
    check("rst_op_code", op_code, 4'h0);
    check("rst_enable",  enable,  1'b0);
    check("rst_busy",    busy,    1'b0);

    btn_op   = 4'h0;
    btn_exec = 1'b0;
    reset_n  = 1'b1;
    count = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (enable || busy) count++;
    end
    check("post_rst_quiet", count, 0);

    // ---------------- Basic exec ----------------
    sw = 16'hA53C;
    press_op(4'b0001);          // btnr
    press_op(4'b0010);          // btnd
    run_exec(20, first, count);
    check("basic_en_edge",  first,   8);
    check("basic_en_count", count,   1);
    check("basic_op_code",  op_code, 4'b0011);
    check("basic_a",        a,       16'hA500);
    check("basic_b",        b,       16'h003C);
    check("basic_idle",     busy,    1'b0);

    // ---------------- Bounce rejection ----------------
    for (int i = 0; i < 15; i++) begin
      btn_op[3] = ~btn_op[3];
      repeat (2) tick();
    end
    btn_op = 4'h0;
    repeat (10) tick();

    run_exec(3, first, count);  // one cycle short of acceptance
    check("short_exec_none", count, 0);
    check("short_exec_idle", busy,  1'b0);

    run_exec(4, first, count);  // exactly long enough
    check("min_exec_count", count,   1);
    check("min_exec_edge",  first,   8);
    check("bounce_op_held", op_code, 4'b0011);

    // ---------------- Toggle and hold ----------------
    press_op(4'b0100);          // btnl
    press_op(4'b0100);          // btnl again: bit 2 back to 0
    sw = 16'h5A5A;
    btn_exec = 1'b1;
    repeat (10) tick();         // past FIRE, now waiting for release
    check("toggle_op_code", op_code, 4'b0011);
    sw = 16'hFFFF;
    repeat (5) tick();
    check("hold_a_busy", a, 16'h5A00);
    check("hold_b_busy", b, 16'h005A);
    btn_exec = 1'b0;
    repeat (15) tick();
    check("hold_a_idle", a, 16'h5A00);
    check("hold_b_idle", b, 16'h005A);

    press_op(4'b1100);          // btnu + btnl together: 0011 ^ 1100
    check("op_code_no_leak", op_code, 4'b0011);

    // ---------------- Hold and re-press ----------------
    btn_exec = 1'b1;
    count = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (enable) count++;
    end
    check("long_hold_count", count, 1);
    check("long_hold_busy",  busy,  1'b1);
    btn_exec = 1'b0;
    busy6 = 1'bx;
    busy7 = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) busy6 = busy;
      if (k == 7) busy7 = busy;
    end
    check("release_busy6", busy6, 1'b1);
    check("release_busy7", busy7, 1'b0);

    run_exec(20, first, count);
    check("repress_count",   count,   1);
    check("repress_edge",    first,   8);
    check("repress_op_code", op_code, 4'b1111);
    check("repress_a",       a,       16'hFF00);
    check("repress_b",       b,       16'h00FF);

    // ---------------- Reset mid-sequence ----------------
    sw = 16'h1111;
    btn_exec = 1'b1;
    repeat (7) tick();          // IDLE -> LOAD on edge 7
    check("pre_rst_busy",   busy,   1'b1);
    check("pre_rst_enable", enable, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",    busy,    1'b0);
    check("mid_rst_enable",  enable,  1'b0);
    check("mid_rst_a",       a,       16'h0000);
    check("mid_rst_b",       b,       16'h0000);
    check("mid_rst_op_code", op_code, 4'h0);
    count = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (enable) count++;
    end
    btn_exec = 1'b0;
    reset_n  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (enable) count++;
    end
    check("mid_rst_no_enable", count, 0);

    // Opcode register was cleared by reset as well.
    sw = 16'h0001;
    run_exec(20, first, count);
    check("after_rst_count",   count,   1);
    check("after_rst_op_code", op_code, 4'h0);
    check("after_rst_b",       b,       16'h0001);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/alu_input_ctrl.md
# alu_input_ctrl

Input-conditioning stage that sits directly upstream of the ALU on the Basys3 board. It synchronizes and debounces the four opcode buttons and the execute button. Each clean press of an opcode button toggles one bit of a held opcode register. A clean execute press snapshots the switches and the opcode into registered operand and opcode outputs, then issues a single-cycle `enable` to the ALU.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Legal minimum 2.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`, input, 1: board clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn_op`, input, 4: raw buttons {btnu, btnl, btnd, btnr}. Bit 3 is btnu.
- `btn_exec`, input, 1: raw execute button (btnc).
- `sw`, input, 16: raw switches.
- `a`, output, 16: registered operand A = {sw[15:8], 8'h00} at snapshot.
- `b`, output, 16: registered operand B = {8'h00, sw[7:0]} at snapshot.
- `op_code`, output, 4: registered opcode snapshot.
- `enable`, output, 1: one-cycle strobe to the ALU.
- `busy`, output, 1: high while an execute sequence is in progress.

## Operation
- **Synchronizers:** every raw input (`btn_op`, `btn_exec`, `sw`) passes through a 2-flop synchronizer. Switches are synchronized only, not debounced.
- **Debounce, per button:**
  - The counter increments while the synced level differs from the stable level.
  - The counter clears whenever the two match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, the stable level flips and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves the stable level unchanged.
- **Edge detect:** a registered rise of a stable level produces a one-cycle press pulse. Releases produce no pulse.
- **Opcode register `op_reg`:**
  - A press pulse on `btn_op[i]` toggles `op_reg[i]`.
  - Toggles are accepted in every FSM state and on several bits in the same cycle.
  - `op_code` changes only at snapshot, never directly from `op_reg`.
- **FSM states:**
  - IDLE: on an exec press pulse, go to LOAD.
  - LOAD: register `a`, `b` and `op_code`, then go to FIRE. `a`/`b` come from the synced switches; `op_code` takes `op_reg` after any toggle landing in that same cycle.
  - FIRE: `enable`=1, then go to WAIT_REL.
  - WAIT_REL: stay until the stable exec level is 0, then go to IDLE.
- **`busy`:** 1 in LOAD, FIRE and WAIT_REL; 0 in IDLE.
- **Exec presses while not in IDLE** are ignored. No queueing.
- **Output hold:** `a`, `b` and `op_code` hold their values until the next LOAD.

## Timing
- **Reset values:** `a`=0, `b`=0, `op_code`=0, `enable`=0, `busy`=0, `op_reg`=0, state IDLE. All synchronizer flops, stable levels and counters are 0.
- **Reset assertion** is asynchronous and takes effect immediately in any state. Mid-sequence, a pending `enable` is suppressed and outputs clear.
- **Button held through reset release:** it is seen as a press once DEBOUNCE_CYCLES clean cycles have elapsed after release.
- **Exec latency:** with `btn_exec` rising and held, `enable` is high exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples it high. The breakdown is 2 sync + DEBOUNCE_CYCLES debounce + 1 edge register + 1 LOAD.
- **Opcode latency:** an opcode toggle lands in `op_reg` DEBOUNCE_CYCLES+3 edges after the raw rise.
- **`enable` width:** exactly 1 cycle per accepted exec press, never back-to-back.
- **Switch sampling:** operands reflect switch values synced 2 cycles before LOAD. A switch change during LOAD is not a hazard; either the old or the new synced value is legal only if it changed in that exact cycle.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- **Reset:** hold `reset_n`=0 with buttons pressed → all outputs 0. Release with buttons idle → no `enable` for 100 cycles.
- **Basic exec:** `sw`=16'hA53C, press btnr then btnd (clean), press btnc for 20 cycles → `op_code`=4'b0011, `a`=16'hA500, `b`=16'h003C. `enable` is high for 1 cycle, 8 edges after btnc rise.
- **Bounce rejection:** btnu toggles 1/0 every 2 cycles for 30 cycles, then rests at 0 → `op_reg` unchanged. A btnc bounce shorter than 4 cycles → no `enable`.
- **Toggle and hold:** press btnl twice → `op_reg` bit2 returns to 0. Change `sw` after FIRE → `a`/`b` unchanged until the next exec.
- **Hold and re-press:** btnc held 200 cycles → exactly one `enable`, `busy` high until 4+3 cycles after release. A second btnc press then gives a second `enable`.
- **Reset mid-sequence:** assert `reset_n`=0 during LOAD → no `enable` pulse, `busy`=0, outputs 0 immediately.
